// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped AHB space with fault capture and counter
module ahb_default_slave #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic [1:0]                hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  input  logic                      err_clr,
  output logic                      err_irq,
  output logic [AHB_ADDR_WIDTH-1:0] err_addr,
  output logic                      err_write,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);
  typedef enum logic [1:0] {OKAY_ST, ERR1_ST, ERR2_ST} state_t;
  state_t                    state_q, state_d;
  logic                      err_irq_q, err_irq_d;
  logic                      err_write_q, err_write_d;
  logic [AHB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                      accept;
  always_comb begin
    accept      = hsel && hready && htrans[1] && state_q != ERR1_ST;
    state_d     = state_q == ERR1_ST ? ERR2_ST : accept ? ERR1_ST : OKAY_ST;
    err_addr_d  = accept ? haddr : err_addr_q;
    err_write_d = accept ? hwrite : err_write_q;
    err_irq_d   = accept ? 1'b1 : err_clr ? 1'b0 : err_irq_q;
    err_cnt_d   = accept ? (err_clr ? ERR_CNT_WIDTH'(1) : &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1)
                : err_clr ? '0 : err_cnt_q;
  end
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= OKAY_ST;
      err_irq_q   <= 1'b0;
      err_write_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      err_irq_q   <= err_irq_d;
      err_write_q <= err_write_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
  assign hreadyout = state_q != ERR1_ST;
  assign hresp     = state_q == OKAY_ST ? 2'b00 : 2'b01;
  assign hrdata    = '0;
  assign err_irq   = err_irq_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ahb_default_slave.sv
// tb_ahb_default_slave: directed checks of the default slave response FSM and fault capture
module tb_ahb_default_slave;
  logic        hclk = 1'b0;
  logic        hreset_n = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic        hready = 1'b1;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        err_clr = 1'b0;
  logic        err_irq;
  logic [31:0] err_addr;
  logic        err_write;
  logic [1:0]  err_cnt;
  int          total = 0;
  int          bad = 0;
  ahb_default_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .ERR_CNT_WIDTH(2)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .err_clr(err_clr), .err_irq(err_irq), .err_addr(err_addr), .err_write(err_write),
    .err_cnt(err_cnt)
  );
  always #5 hclk = ~hclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask
  task automatic bus(input logic s, input logic [1:0] t, input logic r, input logic [31:0] a, input logic w);
    hsel = s;
    htrans = t;
    hready = r;
    haddr = a;
    hwrite = w;
  endtask
  task automatic resp(input string tag, input logic rdy, input logic [1:0] rs);
    chk({tag, "_rdy"}, 32'(hreadyout), 32'(rdy));
    chk({tag, "_resp"}, 32'(hresp), 32'(rs));
    chk({tag, "_rdata"}, hrdata, 32'h0);
  endtask
  initial begin
    #2;
    resp("rst", 1'b1, 2'b00);
    chk("rst_cnt", 32'(err_cnt), 0);
    chk("rst_irq", 32'(err_irq), 0);
    chk("rst_addr", err_addr, 0);
    chk("rst_wr", 32'(err_write), 0);
    tick();
    tick();
    hreset_n = 1'b1;
    bus(1, 2'b10, 1, 32'h3000, 1);
    tick();
    resp("f1_err1", 1'b0, 2'b01);
    bus(1, 2'b00, 0, 32'h0, 0);
    tick();
    resp("f1_err2", 1'b1, 2'b01);
    hready = 1'b1;
    tick();
    resp("f1_okay", 1'b1, 2'b00);
    chk("f1_addr", err_addr, 32'h3000);
    chk("f1_wr", 32'(err_write), 1);
    chk("f1_cnt", 32'(err_cnt), 1);
    chk("f1_irq", 32'(err_irq), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", 32'(err_cnt), 0);
    chk("clr_irq", 32'(err_irq), 0);
    chk("clr_addr_kept", err_addr, 32'h3000);
    chk("clr_wr_kept", 32'(err_write), 1);
    bus(1, 2'b00, 1, 32'h4000, 1);
    tick();
    resp("idle", 1'b1, 2'b00);
    bus(1, 2'b01, 1, 32'h4000, 1);
    tick();
    resp("busy", 1'b1, 2'b00);
    bus(0, 2'b10, 1, 32'h4000, 1);
    tick();
    resp("nosel", 1'b1, 2'b00);
    bus(1, 2'b10, 0, 32'h5000, 1);
    tick();
    resp("nordy", 1'b1, 2'b00);
    chk("nonfault_cnt", 32'(err_cnt), 0);
    chk("nonfault_irq", 32'(err_irq), 0);
    bus(1, 2'b10, 1, 32'h6000, 0);
    tick();
    resp("b2b_err1a", 1'b0, 2'b01);
    bus(1, 2'b11, 1, 32'hdead, 1);
    tick();
    resp("b2b_err2a", 1'b1, 2'b01);
    chk("err1_ignored_addr", err_addr, 32'h6000);
    chk("err1_ignored_cnt", 32'(err_cnt), 1);
    bus(1, 2'b11, 1, 32'h6004, 0);
    tick();
    resp("b2b_err1b", 1'b0, 2'b01);
    bus(1, 2'b00, 0, 32'h0, 0);
    tick();
    resp("b2b_err2b", 1'b1, 2'b01);
    hready = 1'b1;
    tick();
    resp("b2b_okay", 1'b1, 2'b00);
    chk("b2b_addr", err_addr, 32'h6004);
    chk("b2b_cnt", 32'(err_cnt), 2);
    chk("b2b_wr", 32'(err_write), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus(1, 2'b10, 1, 32'h7000 + 32'(i * 4), 1);
      tick();
      bus(1, 2'b00, 0, 32'h0, 0);
      tick();
    end
    hready = 1'b1;
    tick();
    chk("sat_cnt", 32'(err_cnt), 3);
    chk("sat_addr", err_addr, 32'h7010);
    err_clr = 1'b1;
    tick();
    chk("sat_clr_cnt", 32'(err_cnt), 0);
    chk("sat_clr_irq", 32'(err_irq), 0);
    bus(1, 2'b10, 1, 32'h100, 0);
    tick();
    err_clr = 1'b0;
    chk("clr_acc_cnt", 32'(err_cnt), 1);
    chk("clr_acc_irq", 32'(err_irq), 1);
    chk("clr_acc_addr", err_addr, 32'h100);
    resp("pre_rst_err1", 1'b0, 2'b01);
    bus(1, 2'b00, 0, 32'h0, 0);
    #2;
    hreset_n = 1'b0;
    #1;
    resp("async_rst", 1'b1, 2'b00);
    chk("async_rst_cnt", 32'(err_cnt), 0);
    chk("async_rst_irq", 32'(err_irq), 0);
    chk("async_rst_addr", err_addr, 0);
    chk("async_rst_wr", 32'(err_write), 0);
    #1;
    hreset_n = 1'b1;
    hready = 1'b1;
    tick();
    resp("post_rst_okay", 1'b1, 2'b00);
    bus(1, 2'b10, 1, 32'h200, 1);
    tick();
    resp("post_rst_err1", 1'b0, 2'b01);
    chk("post_rst_cnt", 32'(err_cnt), 1);
    bus(0, 2'b00, 1, 32'h0, 0);
    tick();
    tick();
    resp("end_okay", 1'b1, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
